// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    localparam int unsigned ZERO_REG = 31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Per-source forwarding select: the youngest in-flight producer of the source wins.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned ZR    = pipe_pkg::ZERO_REG
) (
    input  logic [REG_W-1:0] i_src,
    input  logic             i_use,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_reg_wr,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_reg_wr,
    output fwd_sel_t         o_sel_c
);

    logic w_valid;

    always_comb begin
        o_sel_c = FWD_RF;
        w_valid = i_use && (i_src != REG_W'(ZR));
        if (w_valid && i_ex_reg_wr && (i_ex_rd == i_src)) begin
            o_sel_c = FWD_EXMEM;
        end else if (w_valid && i_mem_reg_wr && (i_mem_rd == i_src)) begin
            o_sel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stall, flush and freeze control of PC, IF/ID, ID/EX,
// plus registered forwarding selects aligned with the ID/EX outputs.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned ZERO_REG     = pipe_pkg::ZERO_REG,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_Rn,
    input  logic [REG_W-1:0] id_Rm,
    input  logic             id_use_Rn,
    input  logic             id_use_Rm,
    input  logic [REG_W-1:0] id_Rd,
    input  logic             id_reg_wr,
    input  logic             id_mem_to_reg,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    import pipe_pkg::*;

    localparam int unsigned        FC_W       = 2;
    localparam logic [FC_W-1:0]    FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    hz_state_t          r_state, w_state_nxt;
    logic [FC_W-1:0]    r_flush_cnt, w_flush_cnt_nxt;
    logic [REG_W-1:0]   r_ex_rd, r_mem_rd;
    logic               r_ex_reg_wr, r_ex_load, r_mem_reg_wr;
    fwd_sel_t           r_fwd_a, r_fwd_b, w_fwd_a, w_fwd_b;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_load_use, w_stall_inc;

    assign w_load_use = r_ex_load && r_ex_reg_wr && (r_ex_rd != REG_W'(ZERO_REG)) &&
                        ((id_use_Rn && (id_Rn == r_ex_rd)) ||
                         (id_use_Rm && (id_Rm == r_ex_rd)));

    fwd_unit #(.REG_W(REG_W), .ZR(ZERO_REG)) u_fwd_a (
        .i_src        (id_Rn),
        .i_use        (id_use_Rn),
        .i_ex_rd      (r_ex_rd),
        .i_ex_reg_wr  (r_ex_reg_wr),
        .i_mem_rd     (r_mem_rd),
        .i_mem_reg_wr (r_mem_reg_wr),
        .o_sel_c      (w_fwd_a)
    );

    fwd_unit #(.REG_W(REG_W), .ZR(ZERO_REG)) u_fwd_b (
        .i_src        (id_Rm),
        .i_use        (id_use_Rm),
        .i_ex_rd      (r_ex_rd),
        .i_ex_reg_wr  (r_ex_reg_wr),
        .i_mem_rd     (r_mem_rd),
        .i_mem_reg_wr (r_mem_reg_wr),
        .o_sel_c      (w_fwd_b)
    );

    // Priority: freeze, then flush (branch cycle counts as the first squash cycle), then load-use.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        pc_en           = 1'b1;
        ifid_en         = 1'b1;
        ifid_flush      = 1'b0;
        idex_bubble     = 1'b0;
        w_stall_inc     = 1'b0;
        if (mem_busy) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            w_stall_inc = 1'b1;
        end else if (br_taken || (r_state == FLUSH)) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (br_taken) begin
                w_flush_cnt_nxt = FLUSH_LOAD;
                w_state_nxt     = (FLUSH_LOAD != '0) ? FLUSH : RUN;
            end else if (r_flush_cnt <= FC_W'(1)) begin
                w_flush_cnt_nxt = '0;
                w_state_nxt     = RUN;
            end else begin
                w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
            end
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            w_stall_inc = 1'b1;
        end
    end

    // State, shadow pipeline and forwarding registers advance only when not frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RUN;
            r_flush_cnt  <= '0;
            r_ex_rd      <= '0;
            r_ex_reg_wr  <= 1'b0;
            r_ex_load    <= 1'b0;
            r_mem_rd     <= '0;
            r_mem_reg_wr <= 1'b0;
            r_fwd_a      <= FWD_RF;
            r_fwd_b      <= FWD_RF;
        end else if (!mem_busy) begin
            r_state      <= w_state_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
            r_ex_rd      <= idex_bubble ? '0 : id_Rd;
            r_ex_reg_wr  <= idex_bubble ? 1'b0 : id_reg_wr;
            r_ex_load    <= idex_bubble ? 1'b0 : id_mem_to_reg;
            r_mem_rd     <= r_ex_rd;
            r_mem_reg_wr <= r_ex_reg_wr;
            r_fwd_a      <= idex_bubble ? FWD_RF : w_fwd_a;
            r_fwd_b      <= idex_bubble ? FWD_RF : w_fwd_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations (FLUSH_CYCLES=2).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_Rn, id_Rm, id_Rd;
    logic        id_use_Rn, id_use_Rm, id_reg_wr, id_mem_to_reg;
    logic        br_taken, mem_busy;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_W(5), .ZERO_REG(31), .FLUSH_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .id_Rn(id_Rn), .id_Rm(id_Rm), .id_use_Rn(id_use_Rn), .id_use_Rm(id_use_Rm),
        .id_Rd(id_Rd), .id_reg_wr(id_reg_wr), .id_mem_to_reg(id_mem_to_reg),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_en(input string tag, input logic pc, input logic ife,
                            input logic fl, input logic bub);
        check({tag, ".pc_en"}, 32'(pc_en), 32'(pc));
        check({tag, ".ifid_en"}, 32'(ifid_en), 32'(ife));
        check({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
        check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rn, input logic urn, input logic [4:0] rm,
                          input logic urm, input logic [4:0] rd, input logic wr, input logic ld);
        id_Rn = rn; id_use_Rn = urn; id_Rm = rm; id_use_Rm = urm;
        id_Rd = rd; id_reg_wr = wr; id_mem_to_reg = ld;
        #1;
    endtask

    task automatic nop();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; br_taken = 1'b0; mem_busy = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        check("rst.stall", 32'(stall_cnt), 32'd0);
        check("rst.fwd_a", 32'(fwd_a), 32'd0);
        check("rst.fwd_b", 32'(fwd_b), 32'd0);
        check_en("rst", 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        step(); step();

        // ADD X1,X2,X3 ; SUB X4,X1,X5 -> EX/MEM forward on A
        set_id(5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
        check_en("add", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        set_id(5'd1, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        check_en("sub", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        nop();
        check("sub.fwd_a", 32'(fwd_a), 32'd1);
        check("sub.fwd_b", 32'(fwd_b), 32'd0);
        check("sub.stall", 32'(stall_cnt), 32'd0);
        step();
        check("nop.fwd_a", 32'(fwd_a), 32'd0);
        step();

        // LDUR X1,[X2] ; ADD X3,X1,X4 -> one-cycle stall, then MEM/WB forward
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
        step();
        set_id(5'd1, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
        check_en("lu", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("lu.stall", 32'(stall_cnt), 32'd1);
        check("lu.fwd_a_bub", 32'(fwd_a), 32'd0);
        check_en("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("lu.fwd_a", 32'(fwd_a), 32'd2);
        check("lu.fwd_b", 32'(fwd_b), 32'd0);
        nop();
        step(); step();

        // LDUR X31 ; ADD X3,X31,X4 -> XZR is never a hazard
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1);
        step();
        set_id(5'd31, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
        check_en("xzr", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        nop();
        check("xzr.fwd_a", 32'(fwd_a), 32'd0);
        check("xzr.stall", 32'(stall_cnt), 32'd1);
        step(); step();

        // Branch with a load-use pair in ID: flush wins for exactly 2 cycles, no stall
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
        step();
        br_taken = 1'b1;
        set_id(5'd1, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
        check_en("br0", 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        br_taken = 1'b0;
        #1;
        check_en("br1", 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check_en("br2", 1'b1, 1'b1, 1'b0, 1'b0);
        check("br.stall", 32'(stall_cnt), 32'd1);
        check("br.fwd_a", 32'(fwd_a), 32'd0);
        step();
        nop();
        step(); step();

        // Freeze for 3 cycles during a load-use stall
        set_id(5'd5, 1'b1, 5'd6, 1'b1, 5'd2, 1'b1, 1'b0);
        step();
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
        step();
        check("frz.fwd_pre", 32'(fwd_a), 32'd1);
        set_id(5'd1, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
        check_en("lu2", 1'b0, 1'b0, 1'b0, 1'b1);
        mem_busy = 1'b1;
        #1;
        check_en("busy", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("busy.fwd_a", 32'(fwd_a), 32'd1);
        end
        check("busy.stall", 32'(stall_cnt), 32'd4);
        mem_busy = 1'b0;
        #1;
        check_en("lu2_resume", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("lu2.stall", 32'(stall_cnt), 32'd5);
        check("lu2.fwd_bub", 32'(fwd_a), 32'd0);
        check_en("lu2_after", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("lu2.fwd_a", 32'(fwd_a), 32'd2);
        nop();
        step(); step();

        // Saturate the stall counter via freeze, then a load-use stall must not wrap it
        mem_busy = 1'b1;
        repeat (65530) @(posedge clk);
        #1;
        check("sat.stall", 32'(stall_cnt), 32'hFFFF);
        step();
        check("sat.busy", 32'(stall_cnt), 32'hFFFF);
        mem_busy = 1'b0;
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
        step();
        set_id(5'd1, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
        check_en("lu3", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("sat.lu", 32'(stall_cnt), 32'hFFFF);
        step();
        check("sat.fwd_a", 32'(fwd_a), 32'd2);

        // Async reset in the middle of a flush
        br_taken = 1'b1;
        nop();
        step();
        br_taken = 1'b0;
        #1;
        check("flush.mid", 32'(ifid_flush), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.stall", 32'(stall_cnt), 32'd0);
        check("arst.fwd_a", 32'(fwd_a), 32'd0);
        check("arst.fwd_b", 32'(fwd_b), 32'd0);
        check_en("arst", 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_en("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst.stall", 32'(stall_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
